// File: rtl/pipe_reg_pkg.sv
// Shared definitions for the pipe_reg_slice family: timing-mode encodings and the
// width of the occupancy counter.
package pipe_reg_pkg;

  localparam int MODE_FULL = 0;  // main + skid entry, registered ready
  localparam int MODE_FWD  = 1;  // one entry, combinational ready
  localparam int MODE_HALF = 2;  // one entry, one transfer per two cycles

  function automatic int cnt_width(input int depth);
    return $clog2(2 * depth + 2);
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One valid/ready register stage; MODE selects skid (FULL), forward-registered (FWD)
// or half-throughput (HALF) behaviour. flush clears occupancy but leaves data alone.
module pipe_reg_stage
  import pipe_reg_pkg::*;
#(
  parameter int              WIDTH     = 32,
  parameter int              MODE      = MODE_FULL,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);

  logic             main_valid_reg;
  logic [WIDTH-1:0] main_data_reg;
  logic             in_fire;
  logic             out_fire;

  assign out_valid = main_valid_reg;
  assign out_data  = main_data_reg;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid_reg & out_ready;

  if (MODE == MODE_FULL) begin : g_full
    logic             skid_valid_reg;
    logic [WIDTH-1:0] skid_data_reg;

    assign in_ready = ~skid_valid_reg;
    assign occ      = {1'b0, main_valid_reg} + {1'b0, skid_valid_reg};

    always_ff @(posedge clk) begin
      if (!rst) begin
        main_valid_reg <= 1'b0;
        skid_valid_reg <= 1'b0;
        main_data_reg  <= RESET_VAL;
        skid_data_reg  <= RESET_VAL;
      end else if (flush) begin
        main_valid_reg <= 1'b0;
        skid_valid_reg <= 1'b0;
      end else if (skid_valid_reg) begin
        // Skid must drain into main before any new input is taken, preserving order.
        if (out_fire) begin
          main_data_reg  <= skid_data_reg;
          skid_valid_reg <= 1'b0;
        end
      end else if (in_fire) begin
        if (!main_valid_reg || out_fire) begin
          main_data_reg  <= in_data;
          main_valid_reg <= 1'b1;
        end else begin
          skid_data_reg  <= in_data;
          skid_valid_reg <= 1'b1;
        end
      end else if (out_fire) begin
        main_valid_reg <= 1'b0;
      end
    end
  end else begin : g_single
    assign in_ready = (MODE == MODE_FWD) ? (~main_valid_reg | out_ready) : ~main_valid_reg;
    assign occ      = {1'b0, main_valid_reg};

    always_ff @(posedge clk) begin
      if (!rst) begin
        main_valid_reg <= 1'b0;
        main_data_reg  <= RESET_VAL;
      end else if (flush) begin
        main_valid_reg <= 1'b0;
      end else if (in_fire) begin
        main_data_reg  <= in_data;
        main_valid_reg <= 1'b1;
      end else if (out_fire) begin
        main_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_slice.sv
// DEPTH cascaded pipe_reg_stage instances with valid/ready handshake and occupancy count.
// Optional flush port enabled by defining PIPE_REG_FLUSH_EN.
module pipe_reg_slice
  import pipe_reg_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 1,
  parameter int               MODE      = MODE_FULL,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [cnt_width(DEPTH)-1:0] count
`ifdef PIPE_REG_FLUSH_EN
  ,
  input  logic                        flush
`endif
);

  localparam int CW = cnt_width(DEPTH);

  logic flush_i;
`ifdef PIPE_REG_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  if (DEPTH == 0) begin : g_bypass
    logic bypass_unused;
    assign bypass_unused = ^{clk, rst, flush_i};
    assign in_ready  = out_ready;
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign count     = '0;
  end else begin : g_pipe
    logic rst_done_reg;
    logic accept_en;

    // Ready stays low during reset and for the cycle in which reset is released.
    always_ff @(posedge clk) begin
      rst_done_reg <= rst;
    end

    assign accept_en = rst & rst_done_reg & ~flush_i;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             up_valid;
      logic             up_ready;
      logic [WIDTH-1:0] up_data;
      logic             dn_valid;
      logic             dn_ready;
      logic [WIDTH-1:0] dn_data;
      logic [1:0]       occ;
      logic [CW-1:0]    acc;

      if (gi == 0) begin : g_head
        assign up_valid = in_valid & accept_en;
        assign up_data  = in_data;
        assign acc      = CW'(occ);
      end else begin : g_link
        assign up_valid = g_stage[gi-1].dn_valid;
        assign up_data  = g_stage[gi-1].dn_data;
        assign acc      = g_stage[gi-1].acc + CW'(occ);
      end

      if (gi == DEPTH - 1) begin : g_tail
        assign dn_ready = out_ready;
      end else begin : g_mid
        assign dn_ready = g_stage[gi+1].up_ready;
      end

      pipe_reg_stage #(
        .WIDTH    (WIDTH),
        .MODE     (MODE),
        .RESET_VAL(RESET_VAL)
      ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush_i),
        .in_valid (up_valid),
        .in_ready (up_ready),
        .in_data  (up_data),
        .out_valid(dn_valid),
        .out_ready(dn_ready),
        .out_data (dn_data),
        .occ      (occ)
      );
    end

    assign in_ready  = g_stage[0].up_ready & accept_en;
    assign out_valid = g_stage[DEPTH-1].dn_valid;
    assign out_data  = g_stage[DEPTH-1].dn_data;
    assign count     = g_stage[DEPTH-1].acc;
  end

endmodule

// File: tb/tb_pipe_reg_slice.sv
// Bench for pipe_reg_slice: directed reset/stream/backpressure/half/flush cases plus a
// grid of random-traffic instances (all modes, DEPTH 0..4) checked against a queue model.
module tb_pipe_reg_slice;
  import pipe_reg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_pass    = 0;
  int grid_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed instances ----------------
  logic d_rst;
  logic d3_iv, d3_ir, d3_ov, d3_or;
  logic [7:0] d3_id, d3_od;
  logic [cnt_width(3)-1:0] d3_cnt;
  logic d2_iv, d2_ir, d2_ov, d2_or;
  logic [7:0] d2_id, d2_od;
  logic [cnt_width(2)-1:0] d2_cnt;
  logic h1_iv, h1_ir, h1_ov, h1_or;
  logic [7:0] h1_id, h1_od;
  logic [cnt_width(1)-1:0] h1_cnt;
  logic d2_fl;

  pipe_reg_slice #(.WIDTH(8), .DEPTH(3), .MODE(MODE_FULL), .RESET_VAL(8'hA5)) u_d3 (
    .clk(clk), .rst(d_rst), .in_valid(d3_iv), .in_ready(d3_ir), .in_data(d3_id),
    .out_valid(d3_ov), .out_ready(d3_or), .out_data(d3_od), .count(d3_cnt)
`ifdef PIPE_REG_FLUSH_EN
    , .flush(1'b0)
`endif
  );

  pipe_reg_slice #(.WIDTH(8), .DEPTH(2), .MODE(MODE_FULL), .RESET_VAL(8'h00)) u_d2 (
    .clk(clk), .rst(d_rst), .in_valid(d2_iv), .in_ready(d2_ir), .in_data(d2_id),
    .out_valid(d2_ov), .out_ready(d2_or), .out_data(d2_od), .count(d2_cnt)
`ifdef PIPE_REG_FLUSH_EN
    , .flush(d2_fl)
`endif
  );

  pipe_reg_slice #(.WIDTH(8), .DEPTH(1), .MODE(MODE_HALF), .RESET_VAL(8'h00)) u_h1 (
    .clk(clk), .rst(d_rst), .in_valid(h1_iv), .in_ready(h1_ir), .in_data(h1_id),
    .out_valid(h1_ov), .out_ready(h1_or), .out_data(h1_od), .count(h1_cnt)
`ifdef PIPE_REG_FLUSH_EN
    , .flush(1'b0)
`endif
  );

  // ---------------- random grid ----------------
  for (genvar gm = 0; gm < 3; gm++) begin : g_m
    for (genvar gd = 0; gd < 5; gd++) begin : g_d
      localparam int CW  = cnt_width(gd);
      localparam int CAP = (gm == MODE_FULL) ? 2 * gd : gd;
      logic r_rst, iv, ir, ov, orr;
      logic [7:0] id, od;
      logic [CW-1:0] cnt;
      logic [7:0] q[$];

      pipe_reg_slice #(.WIDTH(8), .DEPTH(gd), .MODE(gm), .RESET_VAL(8'h3C)) u_dut (
        .clk(clk), .rst(r_rst), .in_valid(iv), .in_ready(ir), .in_data(id),
        .out_valid(ov), .out_ready(orr), .out_data(od), .count(cnt)
`ifdef PIPE_REG_FLUSH_EN
        , .flush(1'b0)
`endif
      );

      initial begin : stim
        logic inf, outf, stall_prev;
        logic [7:0] data_prev, front;
        string tag;
        tag = $sformatf("m%0d_d%0d", gm, gd);
        r_rst = 1'b0; iv = 1'b0; id = 8'h00; orr = 1'b0;
        inf = 1'b0; stall_prev = 1'b0; data_prev = 8'h00;
        repeat (3) @(posedge clk);
        #1 r_rst = 1'b1;
        step();
        for (int c = 0; c < 500; c++) begin
          // A pending beat is held unchanged until accepted.
          if (!iv || inf) begin
            iv = ($urandom_range(0, 1) == 1);
            id = 8'($urandom);
          end
          orr = ($urandom_range(0, 9) < 3);
          @(negedge clk);
          chk({tag, "_count"}, 32'(cnt), 32'(q.size()));
          chk({tag, "_cap"}, 32'(int'(cnt) <= CAP), 32'd1);
          if (stall_prev) begin
            chk({tag, "_stall_valid"}, 32'(ov), 32'd1);
            chk({tag, "_stall_data"}, 32'(od), 32'(data_prev));
          end
          if (gd == 0) begin
            chk({tag, "_bypass_valid"}, 32'(ov), 32'(iv));
            chk({tag, "_bypass_ready"}, 32'(ir), 32'(orr));
            if (iv) chk({tag, "_bypass_data"}, 32'(od), 32'(id));
          end else begin
            if (q.size() == 0) begin
              chk({tag, "_empty_valid"}, 32'(ov), 32'd0);
              chk({tag, "_empty_ready"}, 32'(ir), 32'd1);
            end
            if (q.size() == CAP && !(gm == MODE_FWD && orr))
              chk({tag, "_full_ready"}, 32'(ir), 32'd0);
          end
          inf  = iv && ir;
          outf = ov && orr;
          if (inf) q.push_back(id);
          if (outf) begin
            if (q.size() == 0) chk({tag, "_pop_empty"}, 32'd1, 32'(q.size()));
            else begin
              front = q.pop_front();
              chk({tag, "_data"}, 32'(od), 32'(front));
            end
          end
          stall_prev = ov && !orr;
          data_prev  = od;
          step();
        end
        iv = 1'b0;
        grid_done = grid_done + 1;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int acc, got, n;
    logic [7:0] nxt;
    d_rst = 1'b0; d2_fl = 1'b0;
    d3_iv = 1'b1; d3_id = 8'h55; d3_or = 1'b0;
    d2_iv = 1'b0; d2_id = 8'h00; d2_or = 1'b0;
    h1_iv = 1'b0; h1_id = 8'h00; h1_or = 1'b0;

    // Reset held three cycles with in_valid asserted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_in_ready", 32'(d3_ir), 32'd0);
      chk("rst_out_valid", 32'(d3_ov), 32'd0);
      chk("rst_count", 32'(d3_cnt), 32'd0);
      chk("rst_out_data", 32'(d3_od), 32'hA5);
    end
    step();
    d_rst = 1'b1; d3_iv = 1'b0;
    step();
    @(negedge clk);
    chk("rst_release_ready", 32'(d3_ir), 32'd1);
    step();

    // Streaming through three FULL stages: beat k appears on cycle k+2.
    d3_or = 1'b1;
    for (int c = 0; c < 24; c++) begin
      d3_iv = (c < 16);
      d3_id = 8'(c + 1);
      @(negedge clk);
      if (c < 16) chk("stream_in_ready", 32'(d3_ir), 32'd1);
      chk("stream_out_valid", 32'(d3_ov), 32'(c >= 3 && c <= 18));
      if (d3_ov) chk("stream_out_data", 32'(d3_od), 32'(c - 2));
      step();
    end
    d3_iv = 1'b0;

    // Backpressure on DEPTH=2 FULL: exactly four beats fit.
    acc = 0; nxt = 8'h11;
    for (int c = 0; c < 10; c++) begin
      d2_iv = 1'b1; d2_id = nxt;
      @(negedge clk);
      if (!d2_ir) break;
      acc = acc + 1; nxt = nxt + 8'h11;
      step();
    end
    chk("bp_accepted", 32'(acc), 32'd4);
    chk("bp_count", 32'(d2_cnt), 32'd4);
    d2_iv = 1'b0;
    step();
    d2_or = 1'b1;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (d2_ov) begin
        got = got + 1;
        chk("bp_drain_data", 32'(d2_od), 32'(17 * got));
      end
      step();
    end
    chk("bp_drained", 32'(got), 32'd4);
    chk("bp_count_empty", 32'(d2_cnt), 32'd0);

`ifdef PIPE_REG_FLUSH_EN
    // Flush with three beats held and a concurrent push.
    d2_or = 1'b0;
    for (int c = 0; c < 3; c++) begin
      d2_iv = 1'b1; d2_id = 8'(8'hA1 + c);
      @(negedge clk);
      chk("fl_fill_ready", 32'(d2_ir), 32'd1);
      step();
    end
    d2_fl = 1'b1; d2_id = 8'h99;
    @(negedge clk);
    chk("fl_count_before", 32'(d2_cnt), 32'd3);
    chk("fl_in_ready", 32'(d2_ir), 32'd0);
    step();
    d2_fl = 1'b0; d2_iv = 1'b0;
    @(negedge clk);
    chk("fl_count_after", 32'(d2_cnt), 32'd0);
    chk("fl_out_valid", 32'(d2_ov), 32'd0);
    step();
    d2_or = 1'b1; d2_iv = 1'b1; d2_id = 8'h77;
    @(negedge clk);
    chk("fl_push_ready", 32'(d2_ir), 32'd1);
    step();
    d2_iv = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge clk);
      if (d2_ov) begin
        got = 1;
        chk("fl_after_data", 32'(d2_od), 32'h77);
      end
      step();
    end
    chk("fl_after_seen", 32'(got), 32'd1);
`endif

    // HALF mode: ready alternates, one beat every two cycles.
    h1_iv = 1'b1; h1_or = 1'b1; n = 1;
    for (int c = 0; c < 10; c++) begin
      h1_id = 8'(n);
      @(negedge clk);
      chk("half_in_ready", 32'(h1_ir), 32'(c % 2 == 0));
      chk("half_out_valid", 32'(h1_ov), 32'(c % 2 == 1));
      if (h1_ov) chk("half_out_data", 32'(h1_od), 32'((c + 1) / 2));
      if (h1_ir) n = n + 1;
      step();
    end
    h1_iv = 1'b0;

    for (int i = 0; i < 3000 && grid_done < 15; i++) @(posedge clk);
    chk("grid_done", 32'(grid_done), 32'd15);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
